// File: rtl/fft_frame_sequencer.sv
// FFT-domain frame sequencer: vsync-triggered start/done handshake, double-buffered bin store, timeout recovery.
// Optional peak search over bins 1..N/2-1 is enabled by defining FFT_FRAME_PEAK_EN.
module fft_frame_sequencer #(
  parameter int unsigned N       = 256,
  parameter int unsigned WIDTH   = 19,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vsync_toggle,
  output logic                   fft_start,
  output logic                   fft_rst,
  input  logic                   fft_done,
  input  logic [N-1:0][WIDTH:0]  freq_mag,
  input  logic [$clog2(N)-1:0]   rd_addr,
  output logic [WIDTH:0]         rd_data,
  output logic                   frame_valid,
  output logic [7:0]             frame_count,
`ifdef FFT_FRAME_PEAK_EN
  output logic [$clog2(N)-1:0]   peak_bin,
  output logic [WIDTH:0]         peak_mag,
`endif
  output logic                   timeout_err
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, COPY, SWAP, ABORT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic             done_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             front_sel_q;
  logic             req_c, done_rise_c;
  logic             start_c, copy_c, swap_c, abort_c;
  logic [WIDTH:0]   buf_mem [2*N];

  assign req_c       = sync_q[1] ^ sync_q[2];
  assign done_rise_c = fft_done & ~done_q;

  // Next-state and per-state strobes
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    copy_c  = 1'b0;
    swap_c  = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE:      if (req_c) state_d = START;
      START: begin
        start_c = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise_c)                           state_d = COPY;
        else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) state_d = ABORT;
      end
      COPY: begin
        copy_c = 1'b1;
        if (idx_q == IDX_W'(N - 1)) state_d = SWAP;
      end
      SWAP: begin
        swap_c  = 1'b1;
        state_d = IDLE;
      end
      ABORT: begin
        abort_c = 1'b1;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      done_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      idx_q       <= '0;
      front_sel_q <= 1'b0;
      fft_start   <= 1'b0;
      fft_rst     <= 1'b0;
      rd_data     <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], vsync_toggle};
      done_q    <= fft_done;
      fft_start <= start_c;
      fft_rst   <= abort_c;
      if (start_c)                  tmo_cnt_q <= '0;
      else if (state_q == WAIT_DONE) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      // idx parks at 0 outside COPY so every copy starts at bin 0
      idx_q <= copy_c ? idx_q + IDX_W'(1) : '0;
      if (swap_c) begin
        front_sel_q <= ~front_sel_q;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end
      if (abort_c) timeout_err <= 1'b1;
      rd_data <= buf_mem[{front_sel_q, rd_addr}];
    end
  end

  // Back-buffer fill; storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (copy_c) buf_mem[{~front_sel_q, idx_q}] <= freq_mag[idx_q];
  end

`ifdef FFT_FRAME_PEAK_EN
  logic [IDX_W-1:0] run_bin_q;
  logic [WIDTH:0]   run_mag_q;
  logic             in_band_c;

  assign in_band_c = (idx_q != '0) && (idx_q < IDX_W'(N / 2));

  // Strict compare keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_bin_q <= '0;
      run_mag_q <= '0;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      if (copy_c) begin
        if (idx_q == '0) begin
          run_bin_q <= '0;
          run_mag_q <= '0;
        end else if (in_band_c && (freq_mag[idx_q] > run_mag_q)) begin
          run_bin_q <= idx_q;
          run_mag_q <= freq_mag[idx_q];
        end
      end
      if (swap_c) begin
        peak_bin <= run_bin_q;
        peak_mag <= run_mag_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: frame completions and read-port data are queued and checked on arrival.
module tb_fft_frame_sequencer;

  localparam int unsigned N       = 256;
  localparam int unsigned WIDTH   = 19;
  localparam int unsigned TIMEOUT = 4096;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  vsync_toggle;
  logic                  fft_start;
  logic                  fft_rst;
  logic                  fft_done;
  logic [N-1:0][WIDTH:0] freq_mag;
  logic [7:0]            rd_addr;
  logic [WIDTH:0]        rd_data;
  logic                  frame_valid;
  logic [7:0]            frame_count;
  logic                  timeout_err;
`ifdef FFT_FRAME_PEAK_EN
  logic [7:0]            peak_bin;
  logic [WIDTH:0]        peak_mag;
`endif

  fft_frame_sequencer #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .vsync_toggle (vsync_toggle),
    .fft_start    (fft_start),
    .fft_rst      (fft_rst),
    .fft_done     (fft_done),
    .freq_mag     (freq_mag),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .frame_valid  (frame_valid),
    .frame_count  (frame_count),
`ifdef FFT_FRAME_PEAK_EN
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
`endif
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned n_start  = 0;
  int unsigned n_rst    = 0;
  logic [7:0]  fc_last  = 8'd0;
  logic [7:0]  fc_q [$];
  logic [WIDTH:0] rd_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counters and frame-completion scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (fft_start) n_start++;
      if (fft_rst)   n_rst++;
      if (frame_count != fc_last) begin
        if (fc_q.size() == 0) begin
          check("fc_unexpected", frame_count, fc_last);
        end else begin
          check("frame_count", frame_count, fc_q.pop_front());
          check("frame_valid", frame_valid, 1);
        end
        fc_last = frame_count;
      end
    end
  end

  task automatic set_ramp(input int m);
    for (int i = 0; i < N; i++) freq_mag[i] = 20'(i * m);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!fft_start && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_frame(input logic [7:0] exp, output int n);
    n = 0;
    while (frame_count != exp && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic read_chk(input logic [7:0] addr, input logic [WIDTH:0] exp);
    rd_addr = addr;
    rd_q.push_back(exp);
    tick();
    check("rd_data", rd_data, rd_q.pop_front());
  endtask

  task automatic toggle_vsync();
    vsync_toggle = ~vsync_toggle;
  endtask

  initial begin
    int n;
    int unsigned st0, rs0, frames_done;
    logic [7:0] exp_fc;

    rst = 1'b0; vsync_toggle = 1'b0; fft_done = 1'b0; freq_mag = '0; rd_addr = '0;
    repeat (3) tick();
    check("rst_fft_start", fft_start, 0);
    check("rst_fft_rst", fft_rst, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b1;
    tick();

    // Frame 1: ramp i*3, done 10 clk after start
    set_ramp(3);
    toggle_vsync();
    wait_start(n);
    check("start_lat", n, 4);
    tick();
    check("start_width", fft_start, 0);
    check("valid_before_swap", frame_valid, 0);
    repeat (9) tick();
    fft_done = 1'b1;
    fc_q.push_back(8'd1);
    wait_frame(8'd1, n);
    check("swap_lat", n, N + 2);
    read_chk(8'd100, 20'd300);
    read_chk(8'd0, 20'd0);
    read_chk(8'd255, 20'd765);
`ifdef FFT_FRAME_PEAK_EN
    check("peak_bin_ramp", peak_bin, 127);
    check("peak_mag_ramp", peak_mag, 381);
`endif

    // Frame 2: done left high must not count as completion
    toggle_vsync();
    wait_start(n);
    check("start_lat_held", n, 4);
    repeat (50) tick();
    check("held_done_count", frame_count, 1);
    fft_done = 1'b0;
    tick();
    set_ramp(7);
    fft_done = 1'b1;
    fc_q.push_back(8'd2);
    wait_frame(8'd2, n);
    check("swap_lat_held", n, N + 2);
    read_chk(8'd100, 20'd700);
    fft_done = 1'b0;

    // Timeout: no done at all
    rs0 = n_rst;
    toggle_vsync();
    wait_start(n);
    check("start_lat_tmo", n, 4);
    n = 0;
    while (!fft_rst && n < int'(TIMEOUT) + 100) begin
      tick();
      n++;
    end
    check("tmo_lat", n, TIMEOUT + 1);
    repeat (3) tick();
    check("tmo_rst_pulses", n_rst - rs0, 1);
    check("timeout_err", timeout_err, 1);
    check("tmo_frame_count", frame_count, 2);
    read_chk(8'd100, 20'd700);

    // Frame 3: toggle during COPY is dropped
    toggle_vsync();
    wait_start(n);
    check("start_lat_drop", n, 4);
    tick();
    st0 = n_start;
    set_ramp(3);
    fft_done = 1'b1;
    fc_q.push_back(8'd3);
    repeat (20) tick();
    toggle_vsync();
    wait_frame(8'd3, n);
    check("frame3_count", frame_count, 3);
    repeat (10) tick();
    check("dropped_req_starts", n_start - st0, 0);
    read_chk(8'd100, 20'd300);
    fft_done = 1'b0;

    // Frame 4: peak pattern
    for (int i = 0; i < N; i++) freq_mag[i] = 20'd1;
    freq_mag[0] = 20'd9999; freq_mag[37] = 20'd500; freq_mag[90] = 20'd500; freq_mag[200] = 20'd900;
    toggle_vsync();
    wait_start(n);
    check("start_lat_peak", n, 4);
    tick();
    fft_done = 1'b1;
    fc_q.push_back(8'd4);
    wait_frame(8'd4, n);
    check("swap_lat_peak", n, N + 2);
    read_chk(8'd0, 20'd9999);
    read_chk(8'd200, 20'd900);
    read_chk(8'd90, 20'd500);
    read_chk(8'd5, 20'd1);
`ifdef FFT_FRAME_PEAK_EN
    check("peak_bin", peak_bin, 37);
    check("peak_mag", peak_mag, 500);
`endif
    fft_done = 1'b0;
    tick();

    // Remaining frames up to the 256th wraps frame_count
    frames_done = 4;
    while (frames_done < 256) begin
      frames_done++;
      exp_fc = 8'(frames_done);
      toggle_vsync();
      wait_start(n);
      check("start_lat_loop", n, 4);
      tick();
      fft_done = 1'b1;
      fc_q.push_back(exp_fc);
      wait_frame(exp_fc, n);
      check("loop_frame_count", frame_count, exp_fc);
      fft_done = 1'b0;
      tick();
    end
    repeat (3) tick();
    check("wrap_count", frame_count, 0);
    check("wrap_valid", frame_valid, 1);
    check("scoreboard_empty", fc_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
